// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if
// Strobe/data bus between the LCD command sequencer and the LCD bus
// controller.
//   nCS  chip select, active low            (master -> slave)
//   nWR  write request, active low          (master -> slave)
//   nRD  read request, active low           (master -> slave)
//   RS   register select, 0=cmd 1=data      (master -> slave)
//   DB   8-bit LCD data bus                 (master -> slave)
//   RDY  controller ready handshake         (slave  -> master)
interface lcd_sequencer_if;
  logic       nCS;
  logic       nWR;
  logic       nRD;
  logic       RS;
  logic [7:0] DB;
  logic       RDY;

  modport master (
    output nCS,
    output nWR,
    output nRD,
    output RS,
    output DB,
    input  RDY
  );

  modport slave (
    input  nCS,
    input  nWR,
    input  nRD,
    input  RS,
    input  DB,
    output RDY
  );
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer
// Upstream command source for the LCD bus controller. After reset it waits
// for LCD power-up, sends the HD44780 init list (0x38, 0x0C, 0x06, 0x01),
// then on each refresh request rewrites the 2x16 display from a 32-byte
// character buffer written by the host.
//
// Optional feature macro: LCD_SEQ_TIMEOUT_EN
//   Defined  : each RDY handshake is bounded by TIMEOUT_CYCLES; on expiry the
//              sticky err flag is set and the current list is abandoned.
//   Undefined: handshake waits are unbounded and err is tied 0.
//
// Ports:
//   clk        system clock, rising edge
//   nRst       asynchronous active-low reset
//   buf_we     host write strobe into the character buffer
//   buf_addr   buffer address, 0-15 line 1, 16-31 line 2
//   buf_data   ASCII character to write
//   refresh    single-cycle pulse requesting a full display rewrite
//   lcd        strobe/data bus to the controller (master modport)
//   init_done  high once the init list has completed
//   seq_busy   high while any transfer or refresh is in progress
//   err        sticky handshake timeout flag
module lcd_sequencer #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned POWER_CYCLES   = CLK_HZ / 25,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  buf_we,
  input  logic [4:0]            buf_addr,
  input  logic [7:0]            buf_data,
  input  logic                  refresh,
  lcd_sequencer_if.master       lcd,
  output logic                  init_done,
  output logic                  seq_busy,
  output logic                  err
);

  if (POWER_CYCLES < 1) begin : g_power_check
    $error("lcd_sequencer: POWER_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_check
    $error("lcd_sequencer: TIMEOUT_CYCLES must fit the 16-bit wait counter");
  end

  typedef enum logic [2:0] {
    stPowerWait,
    stLoad,
    stIssue,
    stWaitLow,
    stWaitHigh,
    stNext,
    stIdle
  } state_t;

  state_t      state;
  logic [31:0] pwr_cnt;
  logic [5:0]  item_idx;
  logic        in_refresh;
  logic        refresh_pend;

  logic        ncs_q;
  logic        nwr_q;
  logic        rs_q;
  logic [7:0]  db_q;
  logic        init_done_q;
  logic        seq_busy_q;

  logic [7:0]  char_buf [32];

  logic [4:0]  buf_idx;
  logic        item_rs;
  logic [7:0]  item_db;
  logic [5:0]  last_idx;

  // Character buffer: written by the host at any time, never reset. The
  // sequencer captures a byte into db_q only in stLoad, so a host write that
  // lands while that byte is on the bus affects the next refresh only.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      char_buf[buf_addr] <= buf_data;
    end
  end

  // Current list item. Init list: 4 commands. Refresh list: 34 items, a
  // set-DDRAM-address command ahead of each 16-character line. Buffer index
  // arithmetic is mod 32: item 1-16 -> buf 0-15, item 18-33 -> buf 16-31.
  always_comb begin
    item_rs = 1'b0;
    item_db = 8'h00;
    buf_idx = 5'd0;
    if (!in_refresh) begin
      case (item_idx[1:0])
        2'd0:    item_db = 8'h38;
        2'd1:    item_db = 8'h0C;
        2'd2:    item_db = 8'h06;
        default: item_db = 8'h01;
      endcase
    end else if (item_idx == 6'd0) begin
      item_db = 8'h80;
    end else if (item_idx <= 6'd16) begin
      buf_idx = item_idx[4:0] - 5'd1;
      item_rs = 1'b1;
      item_db = char_buf[buf_idx];
    end else if (item_idx == 6'd17) begin
      item_db = 8'hC0;
    end else begin
      buf_idx = item_idx[4:0] - 5'd2;
      item_rs = 1'b1;
      item_db = char_buf[buf_idx];
    end
  end

  assign last_idx = in_refresh ? 6'd33 : 6'd3;

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  logic        err_q;
`endif

  // Sequencer FSM. Strobes are registered: nCS/nWR are low exactly while the
  // state register holds stIssue. DB/RS are loaded in stLoad and untouched
  // until the next stLoad, so they are stable across the whole handshake.
  // A refresh pulse in any non-idle state is remembered in refresh_pend;
  // stIdle consumes it (or drops it if init never completed).
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= stPowerWait;
      pwr_cnt      <= '0;
      item_idx     <= '0;
      in_refresh   <= 1'b0;
      refresh_pend <= 1'b0;
      ncs_q        <= 1'b1;
      nwr_q        <= 1'b1;
      rs_q         <= 1'b0;
      db_q         <= 8'h00;
      init_done_q  <= 1'b0;
      seq_busy_q   <= 1'b1;
`ifdef LCD_SEQ_TIMEOUT_EN
      to_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      if (refresh) begin
        refresh_pend <= 1'b1;
      end

      case (state)
        stPowerWait: begin
          if (pwr_cnt == POWER_CYCLES - 1) begin
            pwr_cnt    <= '0;
            item_idx   <= '0;
            in_refresh <= 1'b0;
            state      <= stLoad;
          end else begin
            pwr_cnt <= pwr_cnt + 32'd1;
          end
        end

        stLoad: begin
          db_q  <= item_db;
          rs_q  <= item_rs;
          ncs_q <= 1'b0;
          nwr_q <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= stIssue;
        end

        stIssue: begin
          ncs_q <= 1'b1;
          nwr_q <= 1'b1;
          state <= stWaitLow;
        end

        stWaitLow: begin
`ifdef LCD_SEQ_TIMEOUT_EN
          if (to_cnt == TimeoutLast) begin
            err_q      <= 1'b1;
            seq_busy_q <= 1'b0;
            in_refresh <= 1'b0;
            state      <= stIdle;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (!lcd.RDY) begin
              state <= stWaitHigh;
            end
          end
`else
          if (!lcd.RDY) begin
            state <= stWaitHigh;
          end
`endif
        end

        stWaitHigh: begin
`ifdef LCD_SEQ_TIMEOUT_EN
          if (to_cnt == TimeoutLast) begin
            err_q      <= 1'b1;
            seq_busy_q <= 1'b0;
            in_refresh <= 1'b0;
            state      <= stIdle;
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (lcd.RDY) begin
              state <= stNext;
            end
          end
`else
          if (lcd.RDY) begin
            state <= stNext;
          end
`endif
        end

        stNext: begin
          if (item_idx == last_idx) begin
            if (!in_refresh) begin
              init_done_q <= 1'b1;
            end
            in_refresh <= 1'b0;
            seq_busy_q <= 1'b0;
            state      <= stIdle;
          end else begin
            item_idx <= item_idx + 6'd1;
            state    <= stLoad;
          end
        end

        stIdle: begin
          // A refresh is only honoured once init has completed; after an
          // init-time timeout the display is left alone.
          refresh_pend <= 1'b0;
          if ((refresh || refresh_pend) && init_done_q) begin
            seq_busy_q <= 1'b1;
            in_refresh <= 1'b1;
            item_idx   <= '0;
            state      <= stLoad;
          end else begin
            seq_busy_q <= 1'b0;
          end
        end

        default: begin
          state <= stPowerWait;
        end
      endcase
    end
  end

  assign lcd.nCS  = ncs_q;
  assign lcd.nWR  = nwr_q;
  assign lcd.nRD  = 1'b1;
  assign lcd.RS   = rs_q;
  assign lcd.DB   = db_q;
  assign init_done = init_done_q;
  assign seq_busy  = seq_busy_q;

`ifdef LCD_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
// Self-checking bench for lcd_sequencer. A bench RDY model answers each
// strobe (low 2 cycles after it, high 20 cycles later). Expected {RS,DB}
// items are queued when stimulus is driven and popped as strobes appear.
module tb_lcd_sequencer;
  localparam int unsigned PowerCycles   = 100;
  localparam int unsigned TimeoutCycles = 50;

  typedef struct packed {
    logic       rs;
    logic [7:0] db;
  } item_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         item;
  } wr_t;

  logic       clk = 1'b0;
  logic       nRst;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_data;
  logic       refresh;
  logic       init_done;
  logic       seq_busy;
  logic       err;

  lcd_sequencer_if lcd_bus ();

  lcd_sequencer #(
    .CLK_HZ         (50000000),
    .POWER_CYCLES   (PowerCycles),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .refresh   (refresh),
    .lcd       (lcd_bus),
    .init_done (init_done),
    .seq_busy  (seq_busy),
    .err       (err)
  );

  initial forever #5 clk = ~clk;

  int    checks = 0;
  int    fails = 0;
  int    cycle_count = 0;
  int    strobe_count = 0;
  int    last_strobe_cycle = 0;
  int    release_cycle = 0;
  logic  stuck_rdy = 1'b0;
  item_t exp_q [$];
  item_t strobe_log [$];
  logic [7:0] shadow [32];
  wr_t   writes [10];

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_nCS"}, 32'(lcd_bus.nCS), 32'd1);
    checkOutput({tag, "_nWR"}, 32'(lcd_bus.nWR), 32'd1);
    checkOutput({tag, "_nRD"}, 32'(lcd_bus.nRD), 32'd1);
    checkOutput({tag, "_RS"}, 32'(lcd_bus.RS), 32'd0);
    checkOutput({tag, "_DB"}, 32'(lcd_bus.DB), 32'h00);
    checkOutput({tag, "_init_done"}, 32'(init_done), 32'd0);
    checkOutput({tag, "_seq_busy"}, 32'(seq_busy), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] data);
    buf_we   = 1'b1;
    buf_addr = addr;
    buf_data = data;
    shadow[addr] = data;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic pulseRefresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic pushInit();
    exp_q.push_back('{rs: 1'b0, db: 8'h38});
    exp_q.push_back('{rs: 1'b0, db: 8'h0C});
    exp_q.push_back('{rs: 1'b0, db: 8'h06});
    exp_q.push_back('{rs: 1'b0, db: 8'h01});
  endtask

  task automatic pushRefresh();
    exp_q.push_back('{rs: 1'b0, db: 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back('{rs: 1'b1, db: shadow[i]});
    exp_q.push_back('{rs: 1'b0, db: 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back('{rs: 1'b1, db: shadow[i]});
  endtask

  task automatic waitStrobes(input int target, input int budget, input string name);
    int n = 0;
    while (strobe_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(strobe_count >= target), 32'd1);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while ((seq_busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(seq_busy), 32'd0);
  endtask

  task automatic waitInitDone(input int budget, input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(init_done), 32'd1);
  endtask

  // RDY model: answers every strobe unless stuck_rdy holds RDY high.
  initial begin
    lcd_bus.RDY = 1'b1;
    forever begin
      @(negedge clk);
      if (nRst === 1'b1 && lcd_bus.nCS === 1'b0 && lcd_bus.nWR === 1'b0 && !stuck_rdy) begin
        repeat (2) @(negedge clk);
        lcd_bus.RDY = 1'b0;
        repeat (20) @(negedge clk);
        lcd_bus.RDY = 1'b1;
      end
    end
  end

  // Strobe monitor: scoreboard pop, overlap and DB/RS stability checks.
  initial begin
    logic  outstanding;
    logic  seen_low;
    item_t held;
    item_t got;
    item_t exp;
    outstanding = 1'b0;
    seen_low    = 1'b0;
    held        = '0;
    forever begin
      @(negedge clk);
      if (nRst !== 1'b1) begin
        outstanding = 1'b0;
        seen_low    = 1'b0;
      end else begin
        got = '{rs: lcd_bus.RS, db: lcd_bus.DB};
        if (outstanding) begin
          checkOutput("db_rs_stable", 32'(got), 32'(held));
          if (lcd_bus.RDY === 1'b0) seen_low = 1'b1;
          else if (seen_low) outstanding = 1'b0;
        end
        if (lcd_bus.nCS === 1'b0 && lcd_bus.nWR === 1'b0) begin
          strobe_count++;
          last_strobe_cycle = cycle_count;
          strobe_log.push_back(got);
          checkOutput("no_overlap", 32'(outstanding), 32'd0);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_strobe", 32'(exp_q.size()), 32'd1);
          end else begin
            exp = exp_q.pop_front();
            checkOutput($sformatf("strobe%0d", strobe_count), 32'(got), 32'(exp));
          end
          held        = got;
          outstanding = 1'b1;
          seen_low    = 1'b0;
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    int diff;

    writes = '{
      '{5'd0,  8'h48, 1},  '{5'd1,  8'h45, 2},  '{5'd2,  8'h4C, 3},
      '{5'd3,  8'h4C, 4},  '{5'd4,  8'h4F, 5},  '{5'd16, 8'h57, 18},
      '{5'd17, 8'h4F, 19}, '{5'd18, 8'h52, 20}, '{5'd19, 8'h4C, 21},
      '{5'd20, 8'h44, 22}
    };

    nRst     = 1'b0;
    buf_we   = 1'b0;
    buf_addr = '0;
    buf_data = '0;
    refresh  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("por");

    // Release reset; fill buffer with spaces and request a refresh during init.
    nRst = 1'b1;
    release_cycle = cycle_count;
    pushInit();
    for (int i = 0; i < 32; i++) applyStimulus(5'(i), 8'h20);
    pushRefresh();
    pulseRefresh();
    waitStrobes(1, 300, "first_strobe_seen");
    diff = last_strobe_cycle - release_cycle;
    checkOutput("first_strobe_cycle", 32'(diff >= 100 && diff <= 101), 32'd1);
    checkOutput("init_done_during_list", 32'(init_done), 32'd0);
    pulseRefresh();

    waitInitDone(1000, "init_done_rise");
    checkOutput("strobes_at_init_done", 32'(strobe_count), 32'd4);
    checkOutput("rdy_high_at_init_done", 32'(lcd_bus.RDY), 32'd1);
    waitIdle(2000, "pending_refresh_done");
    checkOutput("strobes_after_pending", 32'(strobe_count), 32'd38);
    repeat (60) @(negedge clk);
    checkOutput("single_pending_refresh", 32'(strobe_count), 32'd38);

    // HELLO / WORLD refresh, checked through the scoreboard and the table.
    for (int i = 0; i < 10; i++) applyStimulus(writes[i].addr, writes[i].data);
    base = strobe_count;
    pushRefresh();
    pulseRefresh();
    waitIdle(2000, "hello_refresh_done");
    checkOutput("hello_strobe_count", 32'(strobe_count - base), 32'd34);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("table_item%0d", writes[i].item),
                  32'(strobe_log[base + writes[i].item]), {23'd0, 1'b1, writes[i].data});
    end

    // Host write to buf[3] while item 4 waits for RDY high.
    base = strobe_count;
    pushRefresh();
    pulseRefresh();
    waitStrobes(base + 5, 400, "item4_strobe");
    n = 0;
    while (lcd_bus.RDY !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("item4_rdy_low", 32'(lcd_bus.RDY), 32'd0);
    @(negedge clk);
    applyStimulus(5'd3, 8'h5A);
    waitIdle(2000, "race_refresh_done");
    checkOutput("race_old_value", 32'(strobe_log[base + 4]), {23'd0, 1'b1, 8'h4C});
    base = strobe_count;
    pushRefresh();
    pulseRefresh();
    waitIdle(2000, "z_refresh_done");
    checkOutput("race_new_value", 32'(strobe_log[base + 4]), {23'd0, 1'b1, 8'h5A});

    // Reset during item 10 of a refresh, then the init list replays.
    base = strobe_count;
    pushRefresh();
    pulseRefresh();
    waitStrobes(base + 11, 600, "item10_strobe");
    #2 nRst = 1'b0;
    #1 checkResetValues("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    release_cycle = cycle_count;
    base = strobe_count;
    pushInit();
    waitStrobes(base + 1, 300, "reinit_first_strobe");
    diff = last_strobe_cycle - release_cycle;
    checkOutput("reinit_first_strobe_cycle", 32'(diff >= 100 && diff <= 101), 32'd1);
    waitInitDone(1000, "reinit_done");
    waitIdle(500, "reinit_idle");
    checkOutput("reinit_strobe_count", 32'(strobe_count - base), 32'd4);

    // RDY never falls after a strobe.
    stuck_rdy = 1'b1;
    base = strobe_count;
    exp_q.push_back('{rs: 1'b0, db: 8'h80});
    pulseRefresh();
    waitStrobes(base + 1, 100, "stuck_strobe");
    n = 0;
    while (cycle_count - last_strobe_cycle < 45 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stuck_err_before_timeout", 32'(err), 32'd0);
    n = 0;
    while (cycle_count - last_strobe_cycle < 56 && n < 200) begin
      @(negedge clk);
      n++;
    end
`ifdef LCD_SEQ_TIMEOUT_EN
    checkOutput("stuck_err_after_timeout", 32'(err), 32'd1);
    checkOutput("stuck_idle_after_timeout", 32'(seq_busy), 32'd0);
`else
    checkOutput("stuck_err_tied_low", 32'(err), 32'd0);
    checkOutput("stuck_still_busy", 32'(seq_busy), 32'd1);
`endif
    repeat (100) @(negedge clk);
    checkOutput("stuck_no_more_strobes", 32'(strobe_count - base), 32'd1);
    checkOutput("stuck_init_done_kept", 32'(init_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
